// File: rtl/axi4_write_sequence.sv
// AXI4 write initiator: fills [pStartAdrs, pStopAdrs) with INCR bursts of a
// running lane pattern (lane x = seed + x), one burst in flight, then raises o_wdone.
module axi4_write_lane #(
  parameter int LW  = 16,
  parameter int IDX = 0
) (
  input  logic [15:0]   seed_i,
  output logic [LW-1:0] lane_o
);
  assign lane_o = LW'(seed_i) + LW'(IDX);
endmodule

module axi4_write_sequence #(
  parameter int          pAxi4BusWidth = 512,
  parameter int          pDataBitWidth = 16,
  parameter logic [31:0] pStartAdrs    = 32'h0000_0000,
  parameter logic [31:0] pStopAdrs     = 32'h0010_0000,
  parameter int          pDdrBurstSize = 16,
  parameter int          pAdrsOffset   = pDdrBurstSize * (pAxi4BusWidth / 8)
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         i_start,
  output logic [32:0]                  o_awaddr,
  output logic [7:0]                   o_awlen,
  output logic [2:0]                   o_awsize,
  output logic [1:0]                   o_awburst,
  output logic [5:0]                   o_awid,
  output logic                         o_awlock,
  output logic                         o_awqos,
  output logic                         o_awapcmd,
  output logic                         o_awvalid,
  input  logic                         i_awready,
  output logic [pAxi4BusWidth-1:0]     o_wdata,
  output logic [pAxi4BusWidth/8-1:0]   o_wstrb,
  output logic                         o_wlast,
  output logic                         o_wvalid,
  input  logic                         i_wready,
  input  logic [5:0]                   i_bid,
  input  logic [1:0]                   i_bresp,
  input  logic                         i_bvalid,
  output logic                         o_bready,
  output logic                         o_wdone,
  output logic [15:0]                  o_werr_cnt
);
  localparam int NUM_LANES = pAxi4BusWidth / pDataBitWidth;
  localparam int STRB_W    = pAxi4BusWidth / 8;
  localparam logic [8:0] LAST_BEAT = 9'(pDdrBurstSize - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [32:0] awaddr_q, awaddr_d;
  logic [8:0]  beat_q, beat_d;
  logic [15:0] seed_q, seed_d;
  logic [15:0] werr_q, werr_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic        bready_q, bready_d, wdone_q, wdone_d;
  logic [32:0] next_addr;
  logic        unused_bid;

  assign unused_bid = ^i_bid;
  assign next_addr  = awaddr_q + 33'(pAdrsOffset);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= S_IDLE;
      awaddr_q  <= {1'b0, pStartAdrs};
      beat_q    <= '0;
      seed_q    <= '0;
      werr_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      wdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      beat_q    <= beat_d;
      seed_q    <= seed_d;
      werr_q    <= werr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      wdone_q   <= wdone_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    beat_d    = beat_q;
    seed_d    = seed_q;
    werr_d    = werr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;
    wdone_d   = wdone_q;
    unique case (state_q)
      S_IDLE: if (i_start) begin
        state_d   = S_AW;
        awvalid_d = 1'b1;
      end
      S_AW: if (awvalid_q && i_awready) begin
        state_d   = S_W;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b1;
        wlast_d   = (LAST_BEAT == 9'd0);
      end
      S_W: if (wvalid_q && i_wready) begin
        beat_d = beat_q + 9'd1;
        seed_d = seed_q + 16'd1;
        if (wlast_q) begin
          state_d  = S_B;
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          bready_d = 1'b1;
        end else begin
          wlast_d = (beat_q + 9'd1 == LAST_BEAT);
        end
      end
      S_B: if (i_bvalid) begin
        bready_d = 1'b0;
        beat_d   = '0;
        awaddr_d = next_addr;
        if (i_bresp != 2'b00 && werr_q != 16'hFFFF) werr_d = werr_q + 16'd1;
        // Any burst that starts below the stop address is written in full.
        if (next_addr >= {1'b0, pStopAdrs}) begin
          state_d = S_DONE;
          wdone_d = 1'b1;
        end else begin
          state_d   = S_AW;
          awvalid_d = 1'b1;
        end
      end
      S_DONE: wdone_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Pattern depends only on the seed register, so data is stable across stalls.
  logic [NUM_LANES-1:0][pDataBitWidth-1:0] lanes;
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    axi4_write_lane #(.LW(pDataBitWidth), .IDX(g)) u_lane (
      .seed_i (seed_q),
      .lane_o (lanes[g])
    );
  end

  assign o_wdata    = lanes;
  assign o_awaddr   = awaddr_q;
  assign o_awlen    = 8'(pDdrBurstSize - 1);
  assign o_awsize   = 3'($clog2(STRB_W));
  assign o_awburst  = 2'b01;
  assign o_awid     = '0;
  assign o_awlock   = 1'b0;
  assign o_awqos    = 1'b0;
  assign o_awapcmd  = 1'b0;
  assign o_awvalid  = awvalid_q;
  assign o_wstrb    = '1;
  assign o_wlast    = wlast_q;
  assign o_wvalid   = wvalid_q;
  assign o_bready   = bready_q;
  assign o_wdone    = wdone_q;
  assign o_werr_cnt = werr_q;
endmodule

// File: tb/tb_axi4_write_sequence.sv
// Scoreboard bench: expected AW addresses and W beats are queued at fill start
// and popped on each handshake; slave-side stalls and errors come from modes.
module tb_axi4_write_sequence;
  logic        iCLK = 1'b0, iRST = 1'b1, i_start = 1'b0;
  logic [32:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp = 2'b00;
  logic [5:0]  awid;
  logic        awlock, awqos, awapcmd, awvalid, wlast, wvalid, bready, wdone;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [15:0] werr;

  axi4_write_sequence #(
    .pAxi4BusWidth(64), .pDataBitWidth(16), .pStartAdrs(32'h0),
    .pStopAdrs(32'h80), .pDdrBurstSize(4), .pAdrsOffset(32)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .i_start(i_start),
    .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
    .o_awid(awid), .o_awlock(awlock), .o_awqos(awqos), .o_awapcmd(awapcmd),
    .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid),
    .i_wready(wready), .i_bid(6'd0), .i_bresp(bresp), .i_bvalid(bvalid),
    .o_bready(bready), .o_wdone(wdone), .o_werr_cnt(werr)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0, n_err = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int aw_stall = 0, aw_wait = 0;
  bit w_toggle = 0, err_mode = 0;
  logic [32:0] aw_q[$];
  logic [63:0] wd_q[$];
  logic        wl_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Slave model: inputs change 1ns after the active edge.
  always @(posedge iCLK) begin
    #1;
    if (!awvalid) aw_wait = 0;
    if (awvalid && aw_wait < aw_stall) begin
      awready = 1'b0;
      aw_wait++;
    end else awready = 1'b1;
    wready = w_toggle ? ~wready : 1'b1;
    bvalid = bready;
    bresp  = (err_mode && (b_cnt == 0 || b_cnt == 2)) ? 2'b10 : 2'b00;
  end

  // Monitor: values at the falling edge are what the next rising edge sees.
  logic        aw_pend = 0, w_pend = 0;
  logic [32:0] aw_prev;
  logic [63:0] wd_prev;
  logic        wl_prev;
  always @(negedge iCLK) begin
    if (iRST) begin
      aw_pend <= 0;
      w_pend  <= 0;
    end else begin
      if (aw_pend) begin
        chk("aw_hold_valid", awvalid, 1);
        chk("aw_hold_addr", awaddr, aw_prev);
      end
      if (w_pend) begin
        chk("w_hold_data", wdata, wd_prev);
        chk("w_hold_last", wlast, wl_prev);
      end
      if (awvalid && awready) begin
        aw_cnt++;
        if (aw_q.size() == 0) chk("aw_extra", 1, 0);
        else chk("awaddr", awaddr, aw_q.pop_front());
      end
      if (wvalid && wready) begin
        w_cnt++;
        if (wd_q.size() == 0) chk("w_extra", 1, 0);
        else begin
          chk("wdata", wdata, wd_q.pop_front());
          chk("wlast", wlast, wl_q.pop_front());
        end
      end
      if (bready && bvalid) b_cnt++;
      aw_pend <= awvalid && !awready;
      aw_prev <= awaddr;
      w_pend  <= wvalid && !wready;
      wd_prev <= wdata;
      wl_prev <= wlast;
    end
  end

  task automatic do_reset();
    @(posedge iCLK); #2;
    iRST = 1'b1;
    i_start = 1'b0;
    repeat (2) @(posedge iCLK);
    #2;
    aw_q.delete(); wd_q.delete(); wl_q.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    iRST = 1'b0;
  endtask

  task automatic push_fill();
    for (int b = 0; b < 4; b++) aw_q.push_back(33'(b * 32));
    for (int k = 0; k < 16; k++) begin
      logic [15:0] s;
      s = 16'(k);
      wd_q.push_back({s + 16'd3, s + 16'd2, s + 16'd1, s});
      wl_q.push_back((k % 4) == 3);
    end
  endtask

  task automatic start_pulse();
    @(posedge iCLK); #2;
    i_start = 1'b1;
    @(posedge iCLK); #2;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!wdone && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    chk(tag, wdone, 1);
    @(negedge iCLK);
    chk({tag, "_aw"}, aw_cnt, 4);
    chk({tag, "_w"}, w_cnt, 16);
    chk({tag, "_b"}, b_cnt, 4);
    chk({tag, "_qempty"}, aw_q.size() + wd_q.size(), 0);
    chk({tag, "_idle"}, {awvalid, wvalid, bready}, 0);
  endtask

  task automatic run_fill(input string tag, input logic [15:0] exp_err);
    do_reset();
    push_fill();
    start_pulse();
    wait_done(tag);
    chk({tag, "_werr"}, werr, exp_err);
  endtask

  initial begin
    do_reset();
    @(negedge iCLK);
    chk("rst_valids", {awvalid, wvalid, wlast, bready, wdone}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_werr", werr, 0);
    chk("awlen", awlen, 3);
    chk("awsize", awsize, 3);
    chk("awburst", awburst, 1);
    chk("awmisc", {awid, awlock, awqos, awapcmd}, 0);
    chk("wstrb", wstrb, 8'hFF);
    repeat (3) @(negedge iCLK);
    chk("idle_no_start", awvalid, 0);

    run_fill("basic", 0);
    aw_stall = 5;
    run_fill("awstall", 0);
    aw_stall = 0;
    w_toggle = 1;
    run_fill("wtoggle", 0);
    w_toggle = 0;
    err_mode = 1;
    run_fill("bresp", 2);
    err_mode = 0;

    // Abort mid-burst, then confirm a clean restart from the first address.
    do_reset();
    push_fill();
    start_pulse();
    begin
      int n = 0;
      while (w_cnt < 6 && n < 500) begin
        @(negedge iCLK);
        n++;
      end
      chk("mid_reach", w_cnt, 6);
    end
    iRST = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    chk("mid_rst_valids", {awvalid, wvalid, wlast, bready, wdone}, 0);
    chk("mid_rst_addr", awaddr, 0);
    chk("mid_rst_wdata", wdata, 64'h0003_0002_0001_0000);
    run_fill("restart", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
